mod_addsub_ctrl: RTL and testbench

Sequencer that performs modular addition or subtraction, (a + b) mod m or (a - b) mod m, on the shared multi-precision adder (mpadder). It issues two adder passes per operation: the raw add/sub, then a correction by m. The correction pass always runs, so latency is constant and independent of the data. The block sits between the Montgomery/exponentiation control layer and one mpadder instance, driving the adder's start, subtract and operand inputs.

---
 rtl/mod_addsub_ctrl.sv | 118 +++++++++++
 tb/tb_mod_addsub_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_addsub_ctrl.sv
// Modular add/sub sequencer: two mpadder passes (raw op, then correction by m); latency 5 cycles plus adder stalls.
// Accepts start only in IDLE (no queueing); stalls indefinitely in WAIT states until add_done.
module mod_addsub_ctrl #(
    parameter int WIDTH = 1027
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             add_start,
    output logic             add_subtract,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH:0]   add_result,
    input  logic             add_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE1 = 3'd1,
        WAIT1  = 3'd2,
        ISSUE2 = 3'd3,
        WAIT2  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   add_a_q, add_a_d;
    logic [WIDTH-1:0]   add_b_q, add_b_d;
    logic               add_sub_q, add_sub_d;
    logic [WIDTH-1:0]   op_m_q, op_m_d;
    logic               op_sub_q, op_sub_d;
    logic [WIDTH:0]     s_q, s_d;
    logic [WIDTH-1:0]   result_q, result_d;

    always_comb begin
        state_d   = state_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_sub_d = add_sub_q;
        op_m_d    = op_m_q;
        op_sub_d  = op_sub_q;
        s_d       = s_q;
        result_d  = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_m_d    = in_m;
                    op_sub_d  = subtract;
                    add_a_d   = in_a;
                    add_b_d   = in_b;
                    add_sub_d = subtract;
                    state_d   = ISSUE1;
                end
            end
            ISSUE1: state_d = WAIT1;
            WAIT1: begin
                // Correction pass: add op subtracts m, subtract op adds m back.
                if (add_done) begin
                    s_d       = add_result;
                    add_a_d   = add_result[WIDTH-1:0];
                    add_b_d   = op_m_q;
                    add_sub_d = ~op_sub_q;
                    state_d   = ISSUE2;
                end
            end
            ISSUE2: state_d = WAIT2;
            WAIT2: begin
                if (add_done) begin
                    if (op_sub_q)
                        result_d = s_q[WIDTH] ? add_result[WIDTH-1:0] : s_q[WIDTH-1:0];
                    else
                        result_d = add_result[WIDTH] ? s_q[WIDTH-1:0] : add_result[WIDTH-1:0];
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            add_a_q   <= '0;
            add_b_q   <= '0;
            add_sub_q <= 1'b0;
            op_m_q    <= '0;
            op_sub_q  <= 1'b0;
            s_q       <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            add_sub_q <= add_sub_d;
            op_m_q    <= op_m_d;
            op_sub_q  <= op_sub_d;
            s_q       <= s_d;
            result_q  <= result_d;
        end
    end

    assign result       = result_q;
    assign done         = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign add_start    = (state_q == ISSUE1) || (state_q == ISSUE2);
    assign add_subtract = add_sub_q;
    assign add_a        = add_a_q;
    assign add_b        = add_b_q;

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Bench for mod_addsub_ctrl: registered adder stub with programmable add_done delay, modular-arithmetic reference model.
module tb_mod_addsub_ctrl;
    localparam int W = 1027;

    logic         clk = 1'b0;
    logic         resetn = 1'b1;
    logic         start = 1'b0;
    logic         subtract = 1'b0;
    logic [W-1:0] in_a = '0, in_b = '0, in_m = '0;
    logic [W-1:0] result, add_a, add_b;
    logic         done, busy, add_start, add_subtract;
    logic [W:0]   add_result = '0;
    logic         add_done;
    int           stub_cnt = 0;
    int           stub_delay = 0;

    int n_checks = 0;
    int n_fail = 0;

    logic [W-1:0] obs_res, obs_ia1, obs_ib1, obs_ia2, obs_ib2;
    logic         obs_is1, obs_is2;
    int           obs_lat, obs_nstart, obs_ndone, obs_unstable, obs_busy_post;

    always #5 clk = ~clk;

    mod_addsub_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .resetn(resetn), .start(start), .subtract(subtract),
        .in_a(in_a), .in_b(in_b), .in_m(in_m), .result(result),
        .done(done), .busy(busy), .add_start(add_start), .add_subtract(add_subtract),
        .add_a(add_a), .add_b(add_b), .add_result(add_result), .add_done(add_done)
    );

    // Adder stub: registers the result on add_start, holds add_done low for stub_delay cycles.
    always @(posedge clk) begin
        if (add_start) begin
            add_result <= add_subtract ? ({1'b0, add_a} - {1'b0, add_b}) : ({1'b0, add_a} + {1'b0, add_b});
            stub_cnt   <= stub_delay;
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
        end
    end
    assign add_done = (stub_cnt == 0);

    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] m, input logic sub);
        logic [W+1:0] aa, bb, mm, r;
        aa = {2'b00, a};
        bb = {2'b00, b};
        mm = {2'b00, m};
        r  = sub ? ((aa + mm - bb) % mm) : ((aa + bb) % mm);
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_wide();
        logic [1055:0] tmp;
        for (int i = 0; i < 33; i++) tmp[i*32 +: 32] = $urandom;
        return tmp[W-1:0];
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m,
                          input logic sub, input int delay, input bit inject);
        logic [W-1:0] ha, hb;
        logic         hs;
        int           post;
        bit           seen;
        ha = '0; hb = '0; hs = 1'b0; post = 0; seen = 0;
        obs_res = '0; obs_lat = -1; obs_nstart = 0; obs_ndone = 0; obs_unstable = 0; obs_busy_post = 0;
        obs_ia1 = '0; obs_ib1 = '0; obs_ia2 = '0; obs_ib2 = '0; obs_is1 = 1'b0; obs_is2 = 1'b0;
        stub_delay = delay;
        @(negedge clk);
        in_a = a; in_b = b; in_m = m; subtract = sub; start = 1'b1;
        for (int n = 1; n <= 200 && post < 3; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (inject && n == 2) begin start = 1'b1; in_a = ~a; in_b = ~b; end
            if (inject && n == 3) start = 1'b0;
            if (add_start) begin
                if (obs_nstart == 0) begin obs_ia1 = add_a; obs_ib1 = add_b; obs_is1 = add_subtract; end
                else if (obs_nstart == 1) begin obs_ia2 = add_a; obs_ib2 = add_b; obs_is2 = add_subtract; end
                obs_nstart++;
                ha = add_a; hb = add_b; hs = add_subtract;
            end else if (busy && (add_a !== ha || add_b !== hb || add_subtract !== hs)) begin
                obs_unstable++;
            end
            if (done) begin
                obs_ndone++;
                if (!seen) begin
                    seen = 1; obs_lat = n; obs_res = result;
                    if (inject) begin start = 1'b1; in_a = ~a; end
                end
            end else if (seen) begin
                post++;
                if (busy) obs_busy_post++;
                if (inject && post == 1) start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1 resetn = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (result !== '0) begin n_fail++; $display("FAIL reset_result got %h exp 0", result[63:0]); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (add_start !== 1'b0) begin n_fail++; $display("FAIL reset_add_start got %b exp 0", add_start); end
        n_checks++; if (add_subtract !== 1'b0) begin n_fail++; $display("FAIL reset_add_subtract got %b exp 0", add_subtract); end
        n_checks++; if (add_a !== '0 || add_b !== '0) begin n_fail++; $display("FAIL reset_add_ops got a=%h b=%h exp 0", add_a[63:0], add_b[63:0]); end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_op(W'(9), W'(7), W'(13), 1'b0, 0, 0);
        n_checks++; if (obs_lat !== 5) begin n_fail++; $display("FAIL basic_latency got %0d exp 5", obs_lat); end
        n_checks++; if (obs_res !== W'(3)) begin n_fail++; $display("FAIL basic_result got %0d exp 3", obs_res[63:0]); end
        n_checks++; if (obs_nstart !== 2) begin n_fail++; $display("FAIL basic_add_start_count got %0d exp 2", obs_nstart); end
        n_checks++; if (obs_ndone !== 1) begin n_fail++; $display("FAIL basic_done_count got %0d exp 1", obs_ndone); end
        n_checks++; if (obs_ia1 !== W'(9) || obs_ib1 !== W'(7) || obs_is1 !== 1'b0) begin
            n_fail++; $display("FAIL basic_issue1 got a=%0d b=%0d s=%b exp 9 7 0", obs_ia1[63:0], obs_ib1[63:0], obs_is1); end
        n_checks++; if (obs_ia2 !== W'(16) || obs_ib2 !== W'(13) || obs_is2 !== 1'b1) begin
            n_fail++; $display("FAIL basic_issue2 got a=%0d b=%0d s=%b exp 16 13 1", obs_ia2[63:0], obs_ib2[63:0], obs_is2); end
        n_checks++; if (obs_busy_post !== 0) begin n_fail++; $display("FAIL basic_busy_after got %0d exp 0", obs_busy_post); end
    endtask

    task automatic test_corners();
        int ta[3] = '{6, 5, 3};
        int tb[3] = '{7, 5, 9};
        bit ts[3] = '{0, 1, 1};
        int te[3] = '{0, 0, 7};
        for (int i = 0; i < 3; i++) begin
            run_op(W'(ta[i]), W'(tb[i]), W'(13), ts[i], 0, 0);
            n_checks++; if (obs_res !== W'(te[i])) begin
                n_fail++; $display("FAIL corner_result[%0d] got %0d exp %0d", i, obs_res[63:0], te[i]); end
            n_checks++; if (obs_lat !== 5) begin n_fail++; $display("FAIL corner_latency[%0d] got %0d exp 5", i, obs_lat); end
        end
    endtask

    task automatic test_wide();
        logic [W-1:0] m, e;
        m = '0; m[1023:0] = '1;
        e = '0; e[1023:0] = '1; e = e - W'(2);
        run_op(m - W'(1), m - W'(1), m, 1'b0, 0, 0);
        n_checks++; if (obs_res !== e) begin n_fail++; $display("FAIL wide_add got %h exp %h", obs_res[127:0], e[127:0]); end
        run_op('0, m - W'(1), m, 1'b1, 0, 0);
        n_checks++; if (obs_res !== W'(1)) begin n_fail++; $display("FAIL wide_sub got %h exp 1", obs_res[127:0]); end
    endtask

    task automatic test_stall();
        run_op(W'(9), W'(7), W'(13), 1'b0, 3, 0);
        n_checks++; if (obs_lat !== 11) begin n_fail++; $display("FAIL stall_latency got %0d exp 11", obs_lat); end
        n_checks++; if (obs_unstable !== 0) begin n_fail++; $display("FAIL stall_operand_stability got %0d changes exp 0", obs_unstable); end
        n_checks++; if (obs_res !== W'(3)) begin n_fail++; $display("FAIL stall_result got %0d exp 3", obs_res[63:0]); end
        n_checks++; if (obs_nstart !== 2) begin n_fail++; $display("FAIL stall_add_start_count got %0d exp 2", obs_nstart); end
    endtask

    task automatic test_ignore_start();
        run_op(W'(9), W'(7), W'(13), 1'b0, 0, 1);
        n_checks++; if (obs_ndone !== 1) begin n_fail++; $display("FAIL ignore_done_count got %0d exp 1", obs_ndone); end
        n_checks++; if (obs_res !== W'(3)) begin n_fail++; $display("FAIL ignore_result got %0d exp 3", obs_res[63:0]); end
        n_checks++; if (obs_busy_post !== 0) begin n_fail++; $display("FAIL ignore_busy_after got %0d exp 0", obs_busy_post); end
        n_checks++; if (obs_lat !== 5) begin n_fail++; $display("FAIL ignore_latency got %0d exp 5", obs_lat); end
        n_checks++; if (result !== W'(3)) begin n_fail++; $display("FAIL ignore_result_held got %0d exp 3", result[63:0]); end
    endtask

    task automatic test_random();
        logic [W-1:0] m, a, b, mask, e;
        logic         sub;
        int           d;
        for (int i = 0; i < 40; i++) begin
            mask = '1;
            mask = mask >> $urandom_range(1, W - 2);
            m = rand_wide() & mask;
            if (m == '0) m = W'(1);
            a = rand_wide() % m;
            b = rand_wide() % m;
            sub = 1'($urandom_range(0, 1));
            d = $urandom_range(0, 2);
            e = model(a, b, m, sub);
            run_op(a, b, m, sub, d, 0);
            n_checks++; if (obs_res !== e) begin
                n_fail++; $display("FAIL random_result[%0d] sub=%b got %h exp %h", i, sub, obs_res[127:0], e[127:0]); end
            n_checks++; if (obs_lat !== 5 + 2 * d) begin
                n_fail++; $display("FAIL random_latency[%0d] got %0d exp %0d", i, obs_lat, 5 + 2 * d); end
        end
    endtask

    task automatic test_reset_mid();
        int dcount;
        stub_delay = 3;
        @(negedge clk);
        in_a = W'(9); in_b = W'(7); in_m = W'(13); subtract = 1'b0; start = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before got %b exp 1", busy); end
        resetn = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b exp 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done got %b exp 0", done); end
        n_checks++; if (add_start !== 1'b0) begin n_fail++; $display("FAIL midreset_add_start got %b exp 0", add_start); end
        n_checks++; if (result !== '0) begin n_fail++; $display("FAIL midreset_result got %h exp 0", result[63:0]); end
        dcount = 0;
        repeat (2) begin @(negedge clk); if (done) dcount++; end
        resetn = 1'b1;
        repeat (6) begin @(negedge clk); if (done) dcount++; end
        n_checks++; if (dcount !== 0) begin n_fail++; $display("FAIL midreset_stale_done got %0d exp 0", dcount); end
        run_op(W'(3), W'(9), W'(13), 1'b1, 0, 0);
        n_checks++; if (obs_res !== W'(7)) begin n_fail++; $display("FAIL midreset_after_result got %0d exp 7", obs_res[63:0]); end
        n_checks++; if (obs_ndone !== 1) begin n_fail++; $display("FAIL midreset_after_done_count got %0d exp 1", obs_ndone); end
        n_checks++; if (obs_lat !== 5) begin n_fail++; $display("FAIL midreset_after_latency got %0d exp 5", obs_lat); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_wide();
        test_stall();
        test_ignore_start();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
